// File: rtl/tx_route_tagger.sv
// tx_route_tagger: TX-side route lookup stage.
// Each accepted descriptor drives one route_table read. The registered
// result is attached to the descriptor, which is then presented downstream.
// Invalid table entries are either dropped or forwarded with a default route
// and the miss flag set. Hit/miss lookups are counted with saturating counters.
module tx_route_tagger #(
  parameter int          INDEX_BITS    = 8,
  parameter int          META_BITS     = 64,
  parameter bit          DROP_MISS     = 1'b1,
  parameter logic [13:0] DEFAULT_ROUTE = 14'h0,
  parameter int          CNT_BITS      = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  s_req_valid,
  output logic                  s_req_ready,
  input  logic [INDEX_BITS-1:0] s_req_index,
  input  logic [META_BITS-1:0]  s_req_meta,
  output logic                  rt_rd_en,
  output logic [INDEX_BITS-1:0] rt_rd_index,
  input  logic [13:0]           rt_rd_route_id,
  input  logic                  rt_rd_valid,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [INDEX_BITS-1:0] m_index,
  output logic [META_BITS-1:0]  m_meta,
  output logic [13:0]           m_route_id,
  output logic [3:0]            m_receiver_id,
  output logic                  m_miss,
  output logic [CNT_BITS-1:0]   stat_hit_cnt,
  output logic [CNT_BITS-1:0]   stat_miss_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    OUT    = 2'd2
  } state_t;

  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  state_t                state_reg;
  logic [INDEX_BITS-1:0] index_reg;
  logic [META_BITS-1:0]  meta_reg;
  logic [13:0]           route_reg;
  logic                  miss_reg;
  logic                  valid_reg;
  logic [CNT_BITS-1:0]   hit_cnt_reg;
  logic [CNT_BITS-1:0]   miss_cnt_reg;
  logic                  accept;

  // Ready when idle, or when the held output is being taken this cycle.
  always_comb begin
    s_req_ready = 1'b0;
    if (state_reg == IDLE) begin
      s_req_ready = 1'b1;
    end else if (state_reg == OUT) begin
      s_req_ready = m_ready;
    end
  end

  assign accept        = s_req_valid & s_req_ready;
  // The table read is launched in the accept cycle itself so its registered
  // result is available in LOOKUP; otherwise the captured index is parked.
  assign rt_rd_en      = accept;
  assign rt_rd_index   = accept ? s_req_index : index_reg;

  assign m_valid       = valid_reg;
  assign m_index       = index_reg;
  assign m_meta        = meta_reg;
  assign m_route_id    = route_reg;
  assign m_miss        = miss_reg;
  assign m_receiver_id = route_reg[5:2];
  assign stat_hit_cnt  = hit_cnt_reg;
  assign stat_miss_cnt = miss_cnt_reg;

  // Lookup FSM with registered descriptor outputs and saturating statistics.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg    <= IDLE;
      index_reg    <= '0;
      meta_reg     <= '0;
      route_reg    <= '0;
      miss_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (s_req_valid) begin
            index_reg <= s_req_index;
            meta_reg  <= s_req_meta;
            state_reg <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (rt_rd_valid) begin
            route_reg <= rt_rd_route_id;
            miss_reg  <= 1'b0;
            valid_reg <= 1'b1;
            state_reg <= OUT;
            if (hit_cnt_reg != '1) begin
              hit_cnt_reg <= hit_cnt_reg + CNT_ONE;
            end
          end else begin
            if (miss_cnt_reg != '1) begin
              miss_cnt_reg <= miss_cnt_reg + CNT_ONE;
            end
            if (DROP_MISS) begin
              state_reg <= IDLE;
            end else begin
              route_reg <= DEFAULT_ROUTE;
              miss_reg  <= 1'b1;
              valid_reg <= 1'b1;
              state_reg <= OUT;
            end
          end
        end
        OUT: begin
          if (m_ready) begin
            valid_reg <= 1'b0;
            if (s_req_valid) begin
              // Outgoing descriptor transfers on this same edge, so the
              // output registers can take the next descriptor immediately.
              index_reg <= s_req_index;
              meta_reg  <= s_req_meta;
              state_reg <= LOOKUP;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_route_tagger.sv
// Testbench for tx_route_tagger: a dropping instance (dut0) and a forwarding
// instance with 2-bit counters (dut1), both reading a behavioural route_table.
module tb_tx_route_tagger;

  typedef struct {
    bit          sel;
    logic [7:0]  idx;
    logic [63:0] meta;
    bit          exp_out;
    logic [13:0] exp_route;
    logic [3:0]  exp_rcv;
    bit          exp_miss;
  } vec_t;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  logic [7:0]  req_index = '0;
  logic [63:0] req_meta = '0;

  // dut0 signals
  logic        s_req_valid0 = 1'b0, s_req_ready0, rt_rd_en0, rt_rd_valid0 = 1'b0;
  logic [7:0]  rt_rd_index0, m_index0;
  logic [13:0] rt_rd_route_id0 = '0, m_route_id0;
  logic        m_valid0, m_ready0 = 1'b1, m_miss0;
  logic [63:0] m_meta0;
  logic [3:0]  m_receiver_id0;
  logic [31:0] stat_hit_cnt0, stat_miss_cnt0;

  // dut1 signals
  logic        s_req_valid1 = 1'b0, s_req_ready1, rt_rd_en1, rt_rd_valid1 = 1'b0;
  logic [7:0]  rt_rd_index1, m_index1;
  logic [13:0] rt_rd_route_id1 = '0, m_route_id1;
  logic        m_valid1, m_ready1 = 1'b1, m_miss1;
  logic [63:0] m_meta1;
  logic [3:0]  m_receiver_id1;
  logic [1:0]  stat_hit_cnt1, stat_miss_cnt1;

  tx_route_tagger #(.INDEX_BITS(8), .META_BITS(64), .DROP_MISS(1'b1),
                    .DEFAULT_ROUTE(14'h0), .CNT_BITS(32)) dut0 (
    .aclk(aclk), .areset(areset),
    .s_req_valid(s_req_valid0), .s_req_ready(s_req_ready0),
    .s_req_index(req_index), .s_req_meta(req_meta),
    .rt_rd_en(rt_rd_en0), .rt_rd_index(rt_rd_index0),
    .rt_rd_route_id(rt_rd_route_id0), .rt_rd_valid(rt_rd_valid0),
    .m_valid(m_valid0), .m_ready(m_ready0), .m_index(m_index0), .m_meta(m_meta0),
    .m_route_id(m_route_id0), .m_receiver_id(m_receiver_id0), .m_miss(m_miss0),
    .stat_hit_cnt(stat_hit_cnt0), .stat_miss_cnt(stat_miss_cnt0));

  tx_route_tagger #(.INDEX_BITS(8), .META_BITS(64), .DROP_MISS(1'b0),
                    .DEFAULT_ROUTE(14'h0004), .CNT_BITS(2)) dut1 (
    .aclk(aclk), .areset(areset),
    .s_req_valid(s_req_valid1), .s_req_ready(s_req_ready1),
    .s_req_index(req_index), .s_req_meta(req_meta),
    .rt_rd_en(rt_rd_en1), .rt_rd_index(rt_rd_index1),
    .rt_rd_route_id(rt_rd_route_id1), .rt_rd_valid(rt_rd_valid1),
    .m_valid(m_valid1), .m_ready(m_ready1), .m_index(m_index1), .m_meta(m_meta1),
    .m_route_id(m_route_id1), .m_receiver_id(m_receiver_id1), .m_miss(m_miss1),
    .stat_hit_cnt(stat_hit_cnt1), .stat_miss_cnt(stat_miss_cnt1));

  // Behavioural route_table: registered read, one port per DUT.
  logic        tbl_valid [256];
  logic [13:0] tbl_route [256];

  always @(posedge aclk) begin
    if (rt_rd_en0) begin
      rt_rd_route_id0 <= tbl_route[rt_rd_index0];
      rt_rd_valid0    <= tbl_valid[rt_rd_index0];
    end
    if (rt_rd_en1) begin
      rt_rd_route_id1 <= tbl_route[rt_rd_index1];
      rt_rd_valid1    <= tbl_valid[rt_rd_index1];
    end
  end

  // Selected-DUT views used by the vector loop.
  logic cur_sel = 1'b0;
  wire        c_ready = cur_sel ? s_req_ready1   : s_req_ready0;
  wire        c_rd_en = cur_sel ? rt_rd_en1      : rt_rd_en0;
  wire [7:0]  c_rd_ix = cur_sel ? rt_rd_index1   : rt_rd_index0;
  wire        c_valid = cur_sel ? m_valid1       : m_valid0;
  wire [7:0]  c_index = cur_sel ? m_index1       : m_index0;
  wire [63:0] c_meta  = cur_sel ? m_meta1        : m_meta0;
  wire [13:0] c_route = cur_sel ? m_route_id1    : m_route_id0;
  wire [3:0]  c_rcv   = cur_sel ? m_receiver_id1 : m_receiver_id0;
  wire        c_miss  = cur_sel ? m_miss1        : m_miss0;
  wire [31:0] c_hit   = cur_sel ? {30'd0, stat_hit_cnt1}  : stat_hit_cnt0;
  wire [31:0] c_mcnt  = cur_sel ? {30'd0, stat_miss_cnt1} : stat_miss_cnt0;

  int n_vec = 0;
  int n_fail = 0;
  int exp_hit0 = 0, exp_miss0 = 0, exp_hit1 = 0, exp_miss1 = 0;

  // dut0 transfer monitor (sampled mid-low-phase, after inputs settle).
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  logic [7:0]  out_idx [$];
  logic [13:0] out_route [$];
  int          out_cyc [$];
  int          acc_cyc [$];

  always @(negedge aclk) begin
    #2;
    if (!areset && m_valid0 && m_ready0) begin
      out_idx.push_back(m_index0);
      out_route.push_back(m_route_id0);
      out_cyc.push_back(cyc);
    end
    if (!areset && s_req_valid0 && s_req_ready0) acc_cyc.push_back(cyc);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    out_idx.delete();
    out_route.delete();
    out_cyc.delete();
    acc_cyc.delete();
  endtask

  // Stream n requests from s_idx into dut0 with a held valid.
  logic [7:0] s_idx [8];

  task automatic stream0(input int n);
    int guard;
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      s_req_valid0 = 1'b1;
      req_index    = s_idx[i];
      req_meta     = 64'(i);
      #1;
      guard = 0;
      while (!s_req_ready0 && guard < 100) begin
        @(negedge aclk);
        #1;
        guard++;
      end
      if (guard >= 100) chk("stream_timeout", 64'(guard), 64'd0);
    end
    @(negedge aclk);
    s_req_valid0 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    exp_hit0 = 0; exp_miss0 = 0; exp_hit1 = 0; exp_miss1 = 0;
  endtask

  // One descriptor with exact-latency checks: accept at N, m_valid at N+2.
  task automatic do_vec(input int k, input vec_t v);
    cur_sel = v.sel;
    @(negedge aclk);
    req_index = v.idx;
    req_meta  = v.meta;
    if (v.sel) begin s_req_valid1 = 1'b1; m_ready1 = 1'b1; end
    else       begin s_req_valid0 = 1'b1; m_ready0 = 1'b1; end
    #1;
    chk($sformatf("v%0d_ready", k), 64'(c_ready), 64'd1);
    chk($sformatf("v%0d_rd_en", k), 64'(c_rd_en), 64'd1);
    chk($sformatf("v%0d_rd_index", k), 64'(c_rd_ix), 64'(v.idx));
    @(negedge aclk);
    s_req_valid0 = 1'b0;
    s_req_valid1 = 1'b0;
    #1;
    chk($sformatf("v%0d_valid_n1", k), 64'(c_valid), 64'd0);
    chk($sformatf("v%0d_rd_en_n1", k), 64'(c_rd_en), 64'd0);
    @(negedge aclk);
    #1;
    chk($sformatf("v%0d_valid_n2", k), 64'(c_valid), 64'(v.exp_out));
    if (v.exp_out) begin
      chk($sformatf("v%0d_index", k), 64'(c_index), 64'(v.idx));
      chk($sformatf("v%0d_meta", k), c_meta, v.meta);
      chk($sformatf("v%0d_route", k), 64'(c_route), 64'(v.exp_route));
      chk($sformatf("v%0d_rcv", k), 64'(c_rcv), 64'(v.exp_rcv));
      chk($sformatf("v%0d_miss", k), 64'(c_miss), 64'(v.exp_miss));
    end else begin
      chk($sformatf("v%0d_ready_n2", k), 64'(c_ready), 64'd1);
    end
    if (v.exp_out && !v.exp_miss) begin
      if (v.sel) exp_hit1 = (exp_hit1 == 3) ? 3 : exp_hit1 + 1;
      else       exp_hit0++;
    end else begin
      if (v.sel) exp_miss1 = (exp_miss1 == 3) ? 3 : exp_miss1 + 1;
      else       exp_miss0++;
    end
    @(negedge aclk);
    #1;
    chk($sformatf("v%0d_valid_n3", k), 64'(c_valid), 64'd0);
    chk($sformatf("v%0d_hit_cnt", k), 64'(c_hit), v.sel ? 64'(exp_hit1) : 64'(exp_hit0));
    chk($sformatf("v%0d_miss_cnt", k), 64'(c_mcnt), v.sel ? 64'(exp_miss1) : 64'(exp_miss0));
    $display("vec %0d: dut%0d idx=%0d route=%h rcv=%0d miss=%0d valid=%0d hit_cnt=%0d miss_cnt=%0d",
             k, v.sel, v.idx, c_route, c_rcv, c_miss, c_valid, c_hit, c_mcnt);
  endtask

  vec_t vecs [11];
  int   bad;

  initial begin
    for (int i = 0; i < 256; i++) begin
      tbl_valid[i] = 1'b0;
      tbl_route[i] = '0;
    end
    tbl_valid[5]   = 1'b1; tbl_route[5]   = 14'h0048;
    tbl_valid[7]   = 1'b1; tbl_route[7]   = 14'h3FFF;
    tbl_valid[0]   = 1'b1; tbl_route[0]   = 14'h0024;
    tbl_valid[255] = 1'b1; tbl_route[255] = 14'h1234;

    vecs[0]  = '{1'b0, 8'd5,   64'hA5,                  1'b1, 14'h0048, 4'd2,  1'b0};
    vecs[1]  = '{1'b0, 8'd9,   64'h1234,                1'b0, 14'h0000, 4'd0,  1'b0};
    vecs[2]  = '{1'b1, 8'd9,   64'hDEAD,                1'b1, 14'h0004, 4'd1,  1'b1};
    vecs[3]  = '{1'b0, 8'd7,   64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 14'h3FFF, 4'd15, 1'b0};
    vecs[4]  = '{1'b0, 8'd0,   64'h0,                   1'b1, 14'h0024, 4'd9,  1'b0};
    vecs[5]  = '{1'b0, 8'd255, 64'h0123_4567_89AB_CDEF, 1'b1, 14'h1234, 4'd13, 1'b0};
    vecs[6]  = '{1'b1, 8'd5,   64'h77,                  1'b1, 14'h0048, 4'd2,  1'b0};
    vecs[7]  = '{1'b1, 8'd200, 64'h1,                   1'b1, 14'h0004, 4'd1,  1'b1};
    vecs[8]  = '{1'b1, 8'd3,   64'h2,                   1'b1, 14'h0004, 4'd1,  1'b1};
    vecs[9]  = '{1'b1, 8'd4,   64'h3,                   1'b1, 14'h0004, 4'd1,  1'b1};
    vecs[10] = '{1'b0, 8'd100, 64'h55,                  1'b0, 14'h0000, 4'd0,  1'b0};

    // Reset state
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    #1;
    chk("rst_m_valid", 64'(m_valid0), 64'd0);
    chk("rst_m_miss", 64'(m_miss1), 64'd0);
    chk("rst_m_index", 64'(m_index0), 64'd0);
    chk("rst_m_meta", m_meta0, 64'd0);
    chk("rst_m_route", 64'(m_route_id0), 64'd0);
    chk("rst_hit_cnt", 64'(stat_hit_cnt0), 64'd0);
    chk("rst_miss_cnt", 64'(stat_miss_cnt0), 64'd0);
    chk("rst_ready", 64'(s_req_ready0), 64'd1);

    // Single-descriptor vectors (hit, drop, forward, counter saturation)
    for (int k = 0; k < 11; k++) do_vec(k, vecs[k]);

    // Backpressure: three requests, m_ready low for 10 cycles in OUT
    clear_mon();
    s_idx[0] = 8'd0; s_idx[1] = 8'd7; s_idx[2] = 8'd255;
    m_ready0 = 1'b0;
    bad = 0;
    fork
      stream0(3);
      begin
        for (int i = 0; i < 12; i++) begin
          @(negedge aclk);
          #1;
          if (i >= 2 && (!m_valid0 || m_index0 !== 8'd0 || m_route_id0 !== 14'h0024 ||
                         m_meta0 !== 64'd0 || s_req_ready0)) bad++;
        end
        @(negedge aclk);
        m_ready0 = 1'b1;
      end
    join
    repeat (4) @(negedge aclk);
    exp_hit0 += 3;
    chk("bp_stable", 64'(bad), 64'd0);
    chk("bp_count", 64'(out_idx.size()), 64'd3);
    if (out_idx.size() == 3) begin
      chk("bp_order0", 64'(out_idx[0]), 64'd0);
      chk("bp_order1", 64'(out_idx[1]), 64'd7);
      chk("bp_order2", 64'(out_idx[2]), 64'd255);
      chk("bp_route1", 64'(out_route[1]), 64'h3FFF);
      chk("bp_gap1", 64'(out_cyc[1] - out_cyc[0]), 64'd2);
      chk("bp_gap2", 64'(out_cyc[2] - out_cyc[1]), 64'd2);
    end
    chk("bp_hit_cnt", 64'(stat_hit_cnt0), 64'(exp_hit0));
    $display("backpressure: %0d outputs, %0d unstable cycles", out_idx.size(), bad);

    // Back-to-back: 8 hits with valid and ready held high
    clear_mon();
    for (int i = 0; i < 8; i++) s_idx[i] = (i % 4 == 0) ? 8'd5 : (i % 4 == 1) ? 8'd7 :
                                             (i % 4 == 2) ? 8'd0 : 8'd255;
    stream0(8);
    repeat (4) @(negedge aclk);
    exp_hit0 += 8;
    chk("b2b_count", 64'(out_idx.size()), 64'd8);
    if (out_idx.size() == 8 && acc_cyc.size() >= 1) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("b2b_idx%0d", i), 64'(out_idx[i]), 64'(s_idx[i]));
        chk($sformatf("b2b_route%0d", i), 64'(out_route[i]), 64'(tbl_route[s_idx[i]]));
        chk($sformatf("b2b_cyc%0d", i), 64'(out_cyc[i] - acc_cyc[0]), 64'(2 * (i + 1)));
      end
    end
    chk("b2b_hit_cnt", 64'(stat_hit_cnt0), 64'(exp_hit0));
    $display("back-to-back: %0d outputs, hit_cnt=%0d", out_idx.size(), stat_hit_cnt0);

    // Reset while in LOOKUP
    @(negedge aclk);
    m_ready0 = 1'b1;
    s_req_valid0 = 1'b1; req_index = 8'd5; req_meta = 64'hBAD0;
    @(negedge aclk);
    s_req_valid0 = 1'b0;
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    exp_hit0 = 0; exp_miss0 = 0; exp_hit1 = 0; exp_miss1 = 0;
    #1;
    chk("rl_m_valid", 64'(m_valid0), 64'd0);
    chk("rl_hit_cnt", 64'(stat_hit_cnt0), 64'd0);
    chk("rl_miss_cnt", 64'(stat_miss_cnt0), 64'd0);
    chk("rl_ready", 64'(s_req_ready0), 64'd1);
    chk("rl_cnt1", 64'(stat_miss_cnt1), 64'd0);
    clear_mon();
    repeat (4) @(negedge aclk);
    chk("rl_no_out", 64'(out_idx.size()), 64'd0);
    $display("reset in LOOKUP: m_valid=%0d outputs=%0d", m_valid0, out_idx.size());

    // Reset while in OUT (held by backpressure)
    @(negedge aclk);
    m_ready0 = 1'b0;
    s_req_valid0 = 1'b1; req_index = 8'd7; req_meta = 64'hBAD1;
    @(negedge aclk);
    s_req_valid0 = 1'b0;
    @(negedge aclk);
    #1;
    chk("ro_in_out", 64'(m_valid0), 64'd1);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    #1;
    chk("ro_m_valid", 64'(m_valid0), 64'd0);
    chk("ro_hit_cnt", 64'(stat_hit_cnt0), 64'd0);
    chk("ro_ready", 64'(s_req_ready0), 64'd1);
    chk("ro_route", 64'(m_route_id0), 64'd0);
    m_ready0 = 1'b1;
    clear_mon();
    repeat (4) @(negedge aclk);
    chk("ro_no_out", 64'(out_idx.size()), 64'd0);
    $display("reset in OUT: m_valid=%0d outputs=%0d", m_valid0, out_idx.size());

    // One more hit after reset to confirm clean restart
    do_vec(11, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
